lsu_ctrl: RTL and testbench

- Load/store controller for the memory stage of the RISC-V pipeline.
- Turns the memory-stage instruction's load/store into a handshaked data-bus transaction and returns extended load data.
- Drives `valid` into the hazard unit. `valid`=0 means the memory-stage result is not ready, and a dependent instruction in execute must stall.
- Also reports misaligned accesses to the trap/interrupt logic.

---
 rtl/lsu_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store controller for the memory stage: one handshaked data-bus transaction per op.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            valid,
   output logic [XLEN-1:0] load_data,
   output logic            misalign_exc,
   output logic            bus_err,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [3:0]      bus_wstrb,
   output logic [XLEN-1:0] bus_wdata,
   input  logic            bus_gnt,
   input  logic            bus_rvalid,
   input  logic [XLEN-1:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state, state_nx;
   logic        op;
   logic        capture, misalign_go, load_done, timeout_go, timeout_hit;
   logic        load_q;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;

   // funct3[1:0]: 00 byte, 01 half, 1x word (reserved encodings fall into word)
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic res;
      case (f3[1:0])
         2'b00:   res = 1'b0;
         2'b01:   res = off[0];
         default: res = (off != 2'b00);
      endcase
      return res;
   endfunction

   function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] res;
      case (f3[1:0])
         2'b00:   res = 4'b0001 << off;
         2'b01:   res = 4'b0011 << off;
         default: res = 4'b1111;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] res;
      case (f3[1:0])
         2'b00:   res = {4{d[7:0]}};
         2'b01:   res = {2{d[15:0]}};
         default: res = d;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = d[{off, 3'b000} +: 8];
      h = off[1] ? d[31:16] : d[15:0];
      case (f3[1:0])
         2'b00:   res = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
         2'b01:   res = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
         default: res = d;
      endcase
      return res;
   endfunction

   assign op      = mem_read | mem_write;
   assign valid   = ((state == IDLE) && !op) || (state == DONE);
   assign bus_req = (state == REQ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      capture     = 1'b0;
      misalign_go = 1'b0;
      load_done   = 1'b0;
      timeout_go  = 1'b0;
      case (state)
         IDLE: begin
            if (op) begin
               if (is_misaligned(funct3, addr[1:0])) begin
                  state_nx    = DONE;
                  misalign_go = 1'b1;
               end else begin
                  state_nx = REQ;
                  capture  = 1'b1;
               end
            end
         end
         REQ: begin
            // rvalid is deliberately ignored here; read data must follow the grant
            if (bus_gnt) begin
               state_nx = load_q ? WAIT : DONE;
            end else if (timeout_hit) begin
               state_nx   = DONE;
               timeout_go = 1'b1;
            end
         end
         WAIT: begin
            if (bus_rvalid) begin
               state_nx  = DONE;
               load_done = 1'b1;
            end else if (timeout_hit) begin
               state_nx   = DONE;
               timeout_go = 1'b1;
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_addr     <= '0;
         bus_we       <= 1'b0;
         bus_wstrb    <= 4'b0;
         bus_wdata    <= '0;
         load_q       <= 1'b0;
         off_q        <= 2'b0;
         f3_q         <= 3'b0;
         load_data    <= '0;
         misalign_exc <= 1'b0;
      end else begin
         if (capture) begin
            // A simultaneous read+write is handled as a load
            bus_addr  <= {addr[XLEN-1:2], 2'b00};
            bus_we    <= ~mem_read;
            bus_wstrb <= mem_read ? 4'b0 : store_strb(funct3, addr[1:0]);
            bus_wdata <= mem_read ? '0 : store_data(funct3, wdata);
            load_q    <= mem_read;
            off_q     <= addr[1:0];
            f3_q      <= funct3;
         end
         misalign_exc <= misalign_go;
         if (misalign_go || timeout_go) load_data <= '0;
         else if (load_done)            load_data <= extend_load(f3_q, off_q, bus_rdata);
      end
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;

   // The cycle that sees count TIMEOUT_CYCLES-1 is the last bus cycle allowed
   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         bus_err  <= 1'b0;
      end else begin
         if (capture)                             wait_cnt <= '0;
         else if (state == REQ || state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
         bus_err <= timeout_go;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: vector table with a scoreboard plus hand-written corner sequences.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        valid;
   logic [31:0] load_data;
   logic        misalign_exc, bus_err;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_gnt, bus_rvalid;
   logic [31:0] bus_rdata;

   always #5 clk = ~clk;

   lsu_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
      .addr(addr), .wdata(wdata),
      .valid(valid), .load_data(load_data),
      .misalign_exc(misalign_exc), .bus_err(bus_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   int n_total = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gnt_dly;
      int          rv_dly;
      logic [31:0] exp_data;
      logic        exp_mis;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        mis;
      int          lat;
      int          reqs;
   } exp_t;

   exp_t sbq[$];
   vec_t vecs[17];

   function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                               input int gd, input int rvd, input logic [31:0] ed,
                               input logic em, input logic [3:0] es, input logic [31:0] ew);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat;
      v.gnt_dly = gd; v.rv_dly = rvd; v.exp_data = ed; v.exp_mis = em;
      v.exp_strb = es; v.exp_wdata = ew;
      return v;
   endfunction

   task automatic run_op(input vec_t v);
      exp_t e;
      int   cyc, req_seen, wait_seen;
      bit   granted, done;
      e.data = v.exp_data;
      e.mis  = v.exp_mis;
      e.reqs = v.exp_mis ? 0 : v.gnt_dly + 1;
      e.lat  = v.exp_mis ? 2 : (v.rd ? 4 + v.gnt_dly + v.rv_dly : 3 + v.gnt_dly);
      sbq.push_back(e);
      mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
      addr = v.addr; wdata = v.wdata; bus_rdata = v.rdata;
      cyc = 0; req_seen = 0; wait_seen = 0; granted = 0; done = 0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         bus_gnt = 1'b0; bus_rvalid = 1'b0;
         if (cyc == 1) check("exc_clear", {31'b0, misalign_exc}, 32'd0);
         if (valid) begin
            exp_t g;
            done = 1;
            g = sbq.pop_front();
            check("latency", 32'(cyc), 32'(g.lat));
            check("load_data", load_data, g.data);
            check("misalign_exc", {31'b0, misalign_exc}, {31'b0, g.mis});
            check("req_cycles", 32'(req_seen), 32'(g.reqs));
            check("bus_err", {31'b0, bus_err}, 32'd0);
         end else if (bus_req) begin
            if (req_seen == 0) begin
               check("bus_addr", bus_addr, v.addr & 32'hFFFF_FFFC);
               check("bus_we", {31'b0, bus_we}, {31'b0, v.wr & ~v.rd});
               if (v.wr && !v.rd) begin
                  check("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, v.exp_strb});
                  check("bus_wdata", bus_wdata, v.exp_wdata);
               end
            end
            if (req_seen == v.gnt_dly) begin
               bus_gnt = 1'b1;
               granted = 1;
            end
            req_seen++;
         end else if (granted) begin
            if (wait_seen == v.rv_dly) bus_rvalid = 1'b1;
            wait_seen++;
         end
      end
      if (!done) begin
         check("valid_timeout", {31'b0, done}, 32'd1);
         void'(sbq.pop_front());
      end
      @(posedge clk);
      #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int reqs;
      bit seen;
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
      addr = '0; wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

      vecs[0]  = mk(1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 4'h0, 32'h0);
      vecs[1]  = mk(1, 0, 3'b000, 32'h103, 32'h0,        32'h80123456, 1, 2, 32'hFFFFFF80, 0, 4'h0, 32'h0);
      vecs[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0,        32'h80123456, 0, 1, 32'h00000080, 0, 4'h0, 32'h0);
      vecs[3]  = mk(1, 0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 0, 0, 32'hFFFF8001, 0, 4'h0, 32'h0);
      vecs[4]  = mk(1, 0, 3'b101, 32'h102, 32'h0,        32'h80017FFF, 2, 0, 32'h00008001, 0, 4'h0, 32'h0);
      vecs[5]  = mk(1, 0, 3'b001, 32'h100, 32'h0,        32'h1234F00F, 0, 0, 32'hFFFFF00F, 0, 4'h0, 32'h0);
      vecs[6]  = mk(1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 0, 32'h0000007F, 0, 4'h0, 32'h0);
      vecs[7]  = mk(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        2, 0, 32'h0000007F, 0, 4'hC, 32'hABCDABCD);
      vecs[8]  = mk(0, 1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        0, 0, 32'h0000007F, 0, 4'h2, 32'hA5A5A5A5);
      vecs[9]  = mk(0, 1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0,        1, 0, 32'h0000007F, 0, 4'hF, 32'hCAFEF00D);
      vecs[10] = mk(1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 0, 32'h00000000, 1, 4'h0, 32'h0);
      vecs[11] = mk(1, 0, 3'b001, 32'h103, 32'h0,        32'h0,        0, 0, 32'h00000000, 1, 4'h0, 32'h0);
      vecs[12] = mk(0, 1, 3'b010, 32'h402, 32'h11111111, 32'h0,        0, 0, 32'h00000000, 1, 4'h0, 32'h0);
      vecs[13] = mk(1, 1, 3'b010, 32'h500, 32'h99999999, 32'h11223344, 1, 1, 32'h11223344, 0, 4'h0, 32'h0);
      vecs[14] = mk(1, 0, 3'b011, 32'h504, 32'h0,        32'h55667788, 0, 0, 32'h55667788, 0, 4'h0, 32'h0);
      vecs[15] = mk(1, 0, 3'b111, 32'h506, 32'h0,        32'h0,        0, 0, 32'h00000000, 1, 4'h0, 32'h0);
      vecs[16] = mk(1, 0, 3'b100, 32'h100, 32'h0,        32'h123456FE, 0, 0, 32'h000000FE, 0, 4'h0, 32'h0);

      // reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_valid", {31'b0, valid}, 32'd1);
      check("rst_bus_req", {31'b0, bus_req}, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_load_data", load_data, 32'd0);
      check("rst_flags", {28'b0, misalign_exc, bus_err, bus_we, 1'b0}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // back-to-back table ops
      for (int i = 0; i < 17; i++) run_op(vecs[i]);

      // rvalid coinciding with gnt must be ignored
      mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h600;
      bus_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      @(negedge clk);
      check("early_rv_req", {31'b0, bus_req}, 32'd1);
      bus_gnt = 1'b1; bus_rvalid = 1'b1;
      @(negedge clk);
      check("early_rv_valid_lo", {31'b0, valid}, 32'd0);
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h600D600D;
      @(negedge clk);
      bus_rvalid = 1'b0;
      check("early_rv_valid_hi", {31'b0, valid}, 32'd1);
      check("early_rv_data", load_data, 32'h600D600D);
      @(posedge clk);
      #1;

      // reset while waiting for read data
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h700;
      @(negedge clk);
      @(negedge clk);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      check("wait_valid_lo", {31'b0, valid}, 32'd0);
      mem_read = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_wait_req", {31'b0, bus_req}, 32'd0);
      check("rst_wait_addr", bus_addr, 32'd0);
      check("rst_wait_data", load_data, 32'd0);
      check("rst_wait_valid", {31'b0, valid}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      bus_rvalid = 1'b1; bus_rdata = 32'h0000FFFF;
      @(negedge clk);
      bus_rvalid = 1'b0;
      check("rst_discard_data", load_data, 32'd0);
      check("rst_discard_valid", {31'b0, valid}, 32'd1);
      @(posedge clk);
      #1;

      // load whose grant never comes
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h800;
      reqs = 0; seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (valid) seen = 1;
         else if (bus_req) reqs++;
      end
`ifdef LSU_TIMEOUT_EN
      check("to_valid", {31'b0, seen}, 32'd1);
      check("to_req_cycles", 32'(reqs), 32'd8);
      check("to_bus_err", {31'b0, bus_err}, 32'd1);
      check("to_load_data", load_data, 32'd0);
      @(posedge clk);
      #1;
      mem_read = 1'b0;
      @(negedge clk);
      check("to_err_pulse", {31'b0, bus_err}, 32'd0);
`else
      check("nogrant_valid", {31'b0, seen}, 32'd0);
      check("nogrant_req", {31'b0, bus_req}, 32'd1);
      check("nogrant_err", {31'b0, bus_err}, 32'd0);
      mem_read = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("nogrant_recover", {31'b0, valid}, 32'd1);
`endif

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
